// File: rtl/frame_stream_pkg.sv
// Shared types and constants for the frame_stream_gen video timing source.
//   CNT_W   : width of every phase/line counter
//   state_e : timing FSM states
package frame_stream_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_VSYNC     = 3'd1,
        ST_VBP       = 3'd2,
        ST_LINE_WAIT = 3'd3,
        ST_ACTIVE    = 3'd4,
        ST_HBLANK    = 3'd5,
        ST_VFP       = 3'd6
    } state_e;

endpackage

// File: rtl/frame_cyc_counter.sv
// Phase-length counter: loaded with (length-1), counts down, flags the last cycle.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_load       : load i_load_val (has priority over i_dec)
//   i_load_val   : value to load, phase length minus one
//   i_dec        : decrement, saturating at zero
//   o_last       : counter is zero, i.e. current cycle is the last of the phase
module frame_cyc_counter
    import frame_stream_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_last = (r_cnt == '0);

endmodule

// File: rtl/frame_stream_gen.sv
// Transmit-side video timing source: pulls pixels from a ready/valid source and
// emits a vsync/href/gray frame stream with parameterised timing.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   enable          : starts a frame when sampled in IDLE
//   s_valid, s_data : pixel source; s_ready accepts (ACTIVE state only)
//   post_img_vsync  : frame sync, high for VSYNC_CYC cycles
//   post_img_href   : line valid, high H_ACTIVE cycles per line
//   post_img_gray   : pixel, zero when href low or source starved
//   underflow       : sticky, source had no pixel during an active cycle
//   frame_done      : one-cycle pulse at the end of the front porch
//   busy            : high outside IDLE
module frame_stream_gen
    import frame_stream_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_BLANK   = 16,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned VSYNC_CYC = 8,
    parameter int unsigned VBP_CYC   = 32,
    parameter int unsigned VFP_CYC   = 32,
    parameter int unsigned DW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          post_img_vsync,
    output logic          post_img_href,
    output logic [DW-1:0] post_img_gray,
    output logic          underflow,
    output logic          frame_done,
    output logic          busy
);

    state_e           r_state;
    logic [CNT_W-1:0] r_vcnt;
    logic             r_vsync;
    logic             r_href;
    logic [DW-1:0]    r_gray;
    logic             r_underflow;
    logic             r_frame_done;
    logic             r_busy;

    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_dec;
    logic             w_last;
    logic             w_last_line;

    assign w_last_line = (r_vcnt == CNT_W'(V_ACTIVE - 1));

    // Phase counter control: preload the next phase's length on each transition.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        w_dec      = (r_state != ST_IDLE) && (r_state != ST_LINE_WAIT);
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_load     = 1'b1;
                    w_load_val = CNT_W'(VSYNC_CYC - 1);
                end
            end
            ST_VSYNC: begin
                if (w_last) begin
                    w_load     = 1'b1;
                    w_load_val = CNT_W'(VBP_CYC - 1);
                end
            end
            ST_LINE_WAIT: begin
                if (s_valid) begin
                    w_load     = 1'b1;
                    w_load_val = CNT_W'(H_ACTIVE - 1);
                end
            end
            ST_ACTIVE: begin
                if (w_last) begin
                    w_load     = 1'b1;
                    w_load_val = CNT_W'(H_BLANK - 1);
                end
            end
            ST_HBLANK: begin
                if (w_last && w_last_line) begin
                    w_load     = 1'b1;
                    w_load_val = CNT_W'(VFP_CYC - 1);
                end
            end
            default: ;
        endcase
    end

    frame_cyc_counter u_cyc_cnt (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_last     (w_last)
    );

    // Timing FSM with registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_vcnt       <= '0;
            r_vsync      <= 1'b0;
            r_href       <= 1'b0;
            r_gray       <= '0;
            r_underflow  <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_href       <= 1'b0;
            r_gray       <= '0;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state <= ST_VSYNC;
                        r_vsync <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_VSYNC: begin
                    if (w_last) begin
                        r_state <= ST_VBP;
                        r_vsync <= 1'b0;
                    end
                end
                ST_VBP: begin
                    if (w_last) begin
                        r_state <= ST_LINE_WAIT;
                        r_vcnt  <= '0;
                    end
                end
                ST_LINE_WAIT: begin
                    if (s_valid) begin
                        r_state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    // Line length is fixed; a starved cycle emits zero and flags underflow.
                    r_href <= 1'b1;
                    r_gray <= s_valid ? s_data : '0;
                    if (!s_valid) begin
                        r_underflow <= 1'b1;
                    end
                    if (w_last) begin
                        r_state <= ST_HBLANK;
                    end
                end
                ST_HBLANK: begin
                    if (w_last) begin
                        r_vcnt  <= r_vcnt + CNT_W'(1);
                        r_state <= w_last_line ? ST_VFP : ST_LINE_WAIT;
                    end
                end
                ST_VFP: begin
                    if (w_last) begin
                        r_state      <= ST_IDLE;
                        r_frame_done <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s_ready        = (r_state == ST_ACTIVE);
    assign post_img_vsync = r_vsync;
    assign post_img_href  = r_href;
    assign post_img_gray  = r_gray;
    assign underflow      = r_underflow;
    assign frame_done     = r_frame_done;
    assign busy           = r_busy;

endmodule
